// File: rtl/camera_sequencer_pkg.sv
// Shared definitions for the camera sequencer: the capture state encoding,
// exposure-time limits and the exposure clamping helper.
package camera_sequencer_pkg;

    localparam int EXP_W = 5;

    localparam logic [EXP_W-1:0] EXP_MIN     = 5'd2;
    localparam logic [EXP_W-1:0] EXP_MAX     = 5'd30;
    localparam logic [EXP_W-1:0] EXP_DEFAULT = 5'd10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ERASE  = 3'd1,
        ST_EXPOSE = 3'd2,
        ST_RD1    = 3'd3,
        ST_RD2    = 3'd4,
        ST_RD3    = 3'd5,
        ST_RD4    = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    // Restrict a requested exposure to the supported window [EXP_MIN, EXP_MAX].
    function automatic logic [EXP_W-1:0] clamp_exp(input logic [EXP_W-1:0] v);
        logic [EXP_W-1:0] r;
        if (v < EXP_MIN) begin
            r = EXP_MIN;
        end else if (v > EXP_MAX) begin
            r = EXP_MAX;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/camera_sequencer_exp_counter.sv
// exp_counter: loadable down-counter that times the exposure phase.
// Ports:
//   Clk, Reset  - clock and asynchronous active-high reset
//   load        - load load_val this cycle (takes priority over dec)
//   load_val    - value to load
//   dec         - decrement by one this cycle
//   tc          - terminal count, high while the count is zero
module exp_counter
    import camera_sequencer_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [EXP_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [EXP_W-1:0] count_q;
    logic [EXP_W-1:0] count_d;

    // Next count: load wins over decrement, otherwise hold.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec) begin
            count_d = count_q - 5'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q <= 5'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == 5'd0);

endmodule

// File: rtl/camera_sequencer.sv
// camera_sequencer: drives one pixel-array capture cycle
// (erase, expose for N cycles, read two rows with ADC conversions, done).
// Ports:
//   Clk, Reset        - clock and asynchronous active-high reset
//   Init, Abort       - capture request / cancel request (level sampled)
//   Exp_time[4:0]     - requested exposure length in cycles, clamped to [2,30]
//   Erase, Expose     - pixel-array controls, active-high
//   NRE_1, NRE_2      - row read enables, active-low
//   ADC               - convert strobe, active-high
//   Busy, Done        - status: busy outside IDLE, one-cycle completion pulse
// All outputs are flops decoded from the next state so they change on the same
// edge as the state register.
module camera_sequencer
    import camera_sequencer_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Init,
    input  logic             Abort,
    input  logic [EXP_W-1:0] Exp_time,
    output logic             Erase,
    output logic             Expose,
    output logic             NRE_1,
    output logic             NRE_2,
    output logic             ADC,
    output logic             Busy,
    output logic             Done
);

    state_t           state_q, state_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             erase_q, erase_d;
    logic             expose_q, expose_d;
    logic             nre_1_q, nre_1_d;
    logic             nre_2_q, nre_2_d;
    logic             adc_q, adc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic             cnt_tc_s;

    exp_counter u_exp_counter (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (cnt_load_s),
        .load_val (exp_q - 5'd1),
        .dec      (cnt_dec_s),
        .tc       (cnt_tc_s)
    );

    // Next-state logic; Abort overrides every transition outside IDLE.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Init && !Abort) begin
                    state_d = ST_ERASE;
                    exp_d   = clamp_exp(Exp_time);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERASE: begin
                // Counter holds N-1 so EXPOSE lasts N cycles ending at zero.
                state_d    = ST_EXPOSE;
                cnt_load_s = 1'b1;
            end
            ST_EXPOSE: begin
                if (cnt_tc_s) begin
                    state_d = ST_RD1;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_RD1:  state_d = ST_RD2;
            ST_RD2:  state_d = ST_RD3;
            ST_RD3:  state_d = ST_RD4;
            ST_RD4:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (Abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            cnt_load_s = 1'b0;
            cnt_dec_s  = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Output decode from the next state, so the registered outputs track state.
    always_comb begin
        erase_d  = (state_d == ST_ERASE);
        expose_d = (state_d == ST_EXPOSE);
        nre_1_d  = !((state_d == ST_RD1) || (state_d == ST_RD2));
        nre_2_d  = !((state_d == ST_RD3) || (state_d == ST_RD4));
        adc_d    = (state_d == ST_RD2) || (state_d == ST_RD4);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
    end

    // State, latched exposure and output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            exp_q    <= EXP_DEFAULT;
            erase_q  <= 1'b0;
            expose_q <= 1'b0;
            nre_1_q  <= 1'b1;
            nre_2_q  <= 1'b1;
            adc_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            erase_q  <= erase_d;
            expose_q <= expose_d;
            nre_1_q  <= nre_1_d;
            nre_2_q  <= nre_2_d;
            adc_q    <= adc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Erase  = erase_q;
    assign Expose = expose_q;
    assign NRE_1  = nre_1_q;
    assign NRE_2  = nre_2_q;
    assign ADC    = adc_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_camera_sequencer.sv
// Scoreboard bench for camera_sequencer. Each clock the stimulus side steps a
// capture-plan model (a queue of the output vectors a capture must produce)
// and pushes the expected output vector; the monitor pops and compares on the
// falling edge. Vector bits: {Erase, Expose, NRE_1, NRE_2, ADC, Busy, Done}.
`timescale 1us/1ns
module tb_camera_sequencer;

    logic       Clk;
    logic       Reset;
    logic       Init;
    logic       Abort;
    logic [4:0] Exp_time;
    logic       Erase, Expose, NRE_1, NRE_2, ADC, Busy, Done;

    camera_sequencer dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Init     (Init),
        .Abort    (Abort),
        .Exp_time (Exp_time),
        .Erase    (Erase),
        .Expose   (Expose),
        .NRE_1    (NRE_1),
        .NRE_2    (NRE_2),
        .ADC      (ADC),
        .Busy     (Busy),
        .Done     (Done)
    );

    localparam logic [6:0] V_IDLE   = 7'b0011000;
    localparam logic [6:0] V_ERASE  = 7'b1011010;
    localparam logic [6:0] V_EXPOSE = 7'b0111010;
    localparam logic [6:0] V_RD1    = 7'b0001010;
    localparam logic [6:0] V_RD2    = 7'b0001110;
    localparam logic [6:0] V_RD3    = 7'b0010010;
    localparam logic [6:0] V_RD4    = 7'b0010110;
    localparam logic [6:0] V_DONE   = 7'b0011011;

    int         checks = 0;
    int         errors = 0;
    logic [6:0] sb[$];
    logic [6:0] plan[$];
    logic [6:0] last_exp;

    initial begin
        Clk = 1'b0;
        forever #500 Clk = ~Clk;
    end

    // Build the full output sequence of one capture of n exposure cycles,
    // followed by the obligatory IDLE cycle after Done.
    task automatic build_plan(input int n);
        plan.push_back(V_ERASE);
        for (int i = 0; i < n; i++) plan.push_back(V_EXPOSE);
        plan.push_back(V_RD1);
        plan.push_back(V_RD2);
        plan.push_back(V_RD3);
        plan.push_back(V_RD4);
        plan.push_back(V_DONE);
        plan.push_back(V_IDLE);
    endtask

    // One clock edge of the reference model, using the inputs the DUT sampled.
    task automatic model_step();
        logic [6:0] cur;
        int n;
        if (Reset) begin
            plan.delete();
            cur = V_IDLE;
        end else if (plan.size() != 0) begin
            if (Abort) begin
                plan.delete();
                cur = V_IDLE;
            end else begin
                cur = plan.pop_front();
            end
        end else if (Init && !Abort) begin
            n = int'(Exp_time);
            if (n < 2) n = 2;
            if (n > 30) n = 30;
            build_plan(n);
            cur = plan.pop_front();
        end else begin
            cur = V_IDLE;
        end
        last_exp = cur;
        sb.push_back(cur);
    endtask

    // Wait for an edge, record the expectation, then drive the next inputs.
    task automatic tick(input logic i, input logic a, input logic [4:0] e);
        @(posedge Clk);
        #1;
        model_step();
        Init     = i;
        Abort    = a;
        Exp_time = e;
    endtask

    // Assert reset mid-cycle: outputs must already be inactive this cycle.
    task automatic reset_now();
        Reset = 1'b1;
        plan.delete();
        void'(sb.pop_back());
        sb.push_back(V_IDLE);
    endtask

    // Monitor: compare DUT outputs with the scoreboard away from the rising edge.
    always @(negedge Clk) begin
        logic [6:0] act;
        logic [6:0] exp_v;
        if (sb.size() != 0) begin
            exp_v = sb.pop_front();
            act = {Erase, Expose, NRE_1, NRE_2, ADC, Busy, Done};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL outputs at %0t: got %b expected %b", $time, act, exp_v);
            end
            checks++;
            if ((!NRE_1 && !NRE_2) || (ADC && !(NRE_1 ^ NRE_2))) begin
                errors++;
                $display("FAIL nre_adc_exclusive at %0t: got NRE_1=%b NRE_2=%b ADC=%b expected one NRE low with ADC",
                         $time, NRE_1, NRE_2, ADC);
            end
        end
    end

    initial begin
        int guard;
        Reset    = 1'b1;
        Init     = 1'b0;
        Abort    = 1'b0;
        Exp_time = 5'd0;

        // Reset state.
        tick(1'b0, 1'b0, 5'd0);
        Reset = 1'b0;

        // Nominal capture, exposure 10: 16 busy cycles.
        tick(1'b1, 1'b0, 5'd10);
        for (int i = 0; i < 18; i++) tick(1'b0, 1'b0, 5'($urandom_range(0, 31)));

        // Clamping boundaries: 0 -> 2 and 31 -> 30.
        tick(1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 5'd0);
        tick(1'b1, 1'b0, 5'd31);
        for (int i = 0; i < 38; i++) tick(1'b0, 1'b0, 5'd31);

        // Abort during the third exposure cycle.
        tick(1'b1, 1'b0, 5'd10);
        tick(1'b0, 1'b0, 5'd10);
        tick(1'b0, 1'b0, 5'd10);
        tick(1'b0, 1'b0, 5'd10);
        tick(1'b0, 1'b1, 5'd10);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 5'd10);

        // Init held high, exposure 2; Exp_time scrambled while a capture runs.
        tick(1'b1, 1'b0, 5'd2);
        for (int i = 0; i < 30; i++)
            tick(1'b1, 1'b0, (plan.size() != 0) ? 5'($urandom_range(0, 31)) : 5'd2);
        tick(1'b0, 1'b0, 5'd2);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 5'd2);

        // Asynchronous reset during RD2, then Init and Abort together in IDLE.
        tick(1'b1, 1'b0, 5'd5);
        guard = 0;
        while (last_exp !== V_RD2 && guard < 50) begin
            tick(1'b0, 1'b0, 5'd5);
            guard++;
        end
        checks++;
        if (last_exp !== V_RD2) begin
            errors++;
            $display("FAIL reach_rd2: got %b expected %b", last_exp, V_RD2);
        end
        reset_now();
        tick(1'b1, 1'b1, 5'd10);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 5'd10);
        tick(1'b0, 1'b0, 5'd10);
        tick(1'b0, 1'b0, 5'd10);

        // Random traffic with occasional aborts and resets.
        for (int i = 0; i < 2000; i++) begin
            tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 299) == 0) begin
                reset_now();
                tick(1'b0, 1'b0, 5'($urandom_range(0, 31)));
                Reset = 1'b0;
            end
        end
        tick(1'b0, 1'b0, 5'd0);

        @(negedge Clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
